// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boots the PC from the reset vector,
// then streams words to decode and tags each LDM immediate.
module fetch_sequencer #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_target,
  output logic [15:0] pc,
  output logic [15:0] inst_out,
  output logic [15:0] last_out,
  output logic        inst_valid,
  output logic        is_imm
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    IMM
  } state_t;

  localparam logic [4:0] OP_LDM = 5'b00111;
  localparam logic [4:0] OP_RST = 5'b11110;

  state_t     state;
  logic       held;
  logic       accept;
  logic [4:0] op;

  // Request whenever out of reset and decode is not stalled.
  assign imem_req  = rst_n & ~stall;
  assign imem_addr = (state == BOOT) ? RESET_ADDR : pc;
  assign accept    = imem_req & imem_valid;
  assign op        = imem_rdata[15:11];

  // Sequencer state and registered outputs; flush beats stall and accept.
  // `held` marks that inst_out is a fetched word rather than the idle
  // NOP value, so that value is never reported on last_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= 16'h0000;
      inst_out   <= NOP_WORD;
      last_out   <= 16'h0000;
      inst_valid <= 1'b0;
      is_imm     <= 1'b0;
      held       <= 1'b0;
    end else if (flush && state != BOOT) begin
      state      <= FETCH;
      pc         <= flush_target;
      inst_out   <= NOP_WORD;
      last_out   <= 16'h0000;
      inst_valid <= 1'b0;
      is_imm     <= 1'b0;
      held       <= 1'b0;
    end else if (stall) begin
      state <= state;
    end else if (accept) begin
      unique case (state)
        BOOT: begin
          pc         <= imem_rdata;
          state      <= FETCH;
          inst_valid <= 1'b0;
          is_imm     <= 1'b0;
        end
        FETCH, IMM: begin
          last_out   <= held ? inst_out : 16'h0000;
          inst_out   <= imem_rdata;
          held       <= 1'b1;
          inst_valid <= 1'b1;
          is_imm     <= (state == IMM);
          pc         <= pc + 16'd1;
          if (state == IMM)
            state <= FETCH;
          else if (op == OP_LDM)
            state <= IMM;
          else if (op == OP_RST)
            state <= BOOT;
          else
            state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end else begin
      inst_valid <= 1'b0;
      is_imm     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory model with programmable latency,
// scoreboard of expected words, directed state checks.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic [15:0] flush_target;
  logic [15:0] pc;
  logic [15:0] inst_out;
  logic [15:0] last_out;
  logic        inst_valid;
  logic        is_imm;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .flush(flush), .flush_target(flush_target),
    .pc(pc), .inst_out(inst_out), .last_out(last_out),
    .inst_valid(inst_valid), .is_imm(is_imm)
  );

  typedef struct {
    logic [15:0] inst;
    logic [15:0] last;
    logic        imm;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mem [0:65535];
  int          lat = 0;
  int          cnt = 0;
  logic        acc_q = 1'b0;
  logic        stall_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    acc_q   <= imem_req & imem_valid;
    stall_q <= stall;
  end

  // Memory: valid after `lat` waiting cycles, restarts after each accept.
  always @(negedge clk) begin
    #1;
    if (acc_q || !imem_req) cnt = 0;
    else cnt = cnt + 1;
    imem_valid = (cnt >= lat);
    imem_rdata = mem[imem_addr];
  end

  // Monitor: each newly presented word is popped and compared.
  always @(negedge clk) begin
    if (rst_n && inst_valid && !stall_q) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL word: unexpected inst=%h last=%h imm=%b",
                 inst_out, last_out, is_imm);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (inst_out !== e.inst || last_out !== e.last
            || is_imm !== e.imm) begin
          n_bad++;
          $display("FAIL word: got %h/%h/%b want %h/%h/%b",
                   inst_out, last_out, is_imm, e.inst, e.last, e.imm);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] l,
                      input logic m);
    exp_t e;
    e.inst = i;
    e.last = l;
    e.imm  = m;
    sb.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"}, pc, 16'h0000);
    chk({tag, " inst"}, inst_out, 16'hF800);
    chk({tag, " last"}, last_out, 16'h0000);
    chk({tag, " valid"}, {15'd0, inst_valid}, 16'd0);
    chk({tag, " imm"}, {15'd0, is_imm}, 16'd0);
    chk({tag, " req"}, {15'd0, imem_req}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    flush_target = 16'h0000;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0010;
    mem[16'h0001] = 16'hF000;
    mem[16'h0010] = 16'h3800;
    mem[16'h0011] = 16'hF0F0;
    mem[16'h0012] = 16'h1234;
    mem[16'h0013] = 16'h2222;
    mem[16'h0014] = 16'h3801;
    mem[16'h0015] = 16'h5555;
    mem[16'h0200] = 16'h4321;
    mem[16'hFFFF] = 16'h7777;

    @(negedge clk); #2;
    chk_reset("rst");

    // Boot and LDM pair
    push(16'h3800, 16'h0000, 1'b0);
    push(16'hF0F0, 16'h3800, 1'b1);
    push(16'h1234, 16'hF0F0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("boot req", {15'd0, imem_req}, 16'd1);
    chk("boot addr", imem_addr, 16'h0000);
    @(negedge clk); #2;
    chk("boot pc", pc, 16'h0010);
    chk("boot valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    @(negedge clk); #2;
    chk("ldm pc", pc, 16'h0012);
    chk("ldm imm", {15'd0, is_imm}, 16'd1);
    chk("ldm last", last_out, 16'h3800);

    // Stall for three cycles with memory valid
    @(negedge clk);
    stall = 1'b1;
    #2;
    chk("stall req", {15'd0, imem_req}, 16'd0);
    chk("stall pc0", pc, 16'h0013);
    push(16'h2222, 16'h1234, 1'b0);
    push(16'h3801, 16'h2222, 1'b0);
    repeat (3) begin
      @(negedge clk); #2;
      chk("stall pc", pc, 16'h0013);
      chk("stall inst", inst_out, 16'h1234);
      chk("stall valid", {15'd0, inst_valid}, 16'd1);
    end
    stall = 1'b0;
    @(negedge clk); #2;
    chk("post stall pc", pc, 16'h0014);

    // Flush while the LDM immediate is pending
    @(negedge clk);
    flush = 1'b1;
    flush_target = 16'h0200;
    #2;
    chk("ldm2 inst", inst_out, 16'h3801);
    push(16'h4321, 16'h0000, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #2;
    chk("flush pc", pc, 16'h0200);
    chk("flush inst", inst_out, 16'hF800);
    chk("flush last", last_out, 16'h0000);
    chk("flush valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    flush = 1'b1;
    flush_target = 16'hFFFF;
    #2;
    chk("after flush pc", pc, 16'h0201);
    chk("after flush imm", {15'd0, is_imm}, 16'd0);

    // Wrap with two wait states
    push(16'h7777, 16'h0000, 1'b0);
    push(16'h0010, 16'h7777, 1'b0);
    push(16'hF000, 16'h0010, 1'b0);
    push(16'h3800, 16'hF000, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    lat = 2;
    #2;
    chk("wrap addr0", imem_addr, 16'hFFFF);
    repeat (2) begin
      @(negedge clk); #2;
      chk("wrap addr", imem_addr, 16'hFFFF);
      chk("wrap valid", {15'd0, inst_valid}, 16'd0);
    end
    lat = 0;
    @(negedge clk); #2;
    chk("wrap pc", pc, 16'h0000);

    // RESET opcode reboots from the vector
    @(negedge clk);
    @(negedge clk); #2;
    chk("rstop addr", imem_addr, 16'h0000);
    chk("rstop inst", inst_out, 16'hF000);
    @(negedge clk); #2;
    chk("reboot pc", pc, 16'h0010);
    chk("reboot valid", {15'd0, inst_valid}, 16'd0);

    // Asynchronous reset in the middle of an LDM pair
    @(negedge clk); #2;
    chk("mid ldm pc", pc, 16'h0011);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    push(16'h3800, 16'h0000, 1'b0);
    push(16'hF0F0, 16'h3800, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #2;
    chk("reldm imm", {15'd0, is_imm}, 16'd1);
    chk("reldm last", last_out, 16'h3800);
    chk("reldm pc", pc, 16'h0012);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("sb empty", sb.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
